// File: rtl/lock_pkg.sv
// Shared types and sizes for the keypad lock controller.
// A code is NDIG keypad digits of DIGIT_W bits each, packed most-recent-last.
package lock_pkg;

    localparam int DIGIT_W = 4;
    localparam int CODE_W  = 32;
    localparam int NDIG    = CODE_W / DIGIT_W;
    localparam int COUNT_W = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        NEW_ENTRY,
        COMMIT_A,
        COMMIT_B,
        LOCKOUT
    } lockState_e;

endpackage

// File: rtl/lock_digit_shreg.sv
// Digit shift register with a saturating digit count; the oldest digit falls
// out once more than NDIG digits are keyed in.
module lock_digit_shreg
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] digit,
    output logic [CODE_W-1:0]  code,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            code  <= '0;
            count <= '0;
        end else if (shift) begin
            code <= {code[CODE_W-DIGIT_W-1:0], digit};
            if (count != COUNT_W'(NDIG)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Keypad lock controller: collects a code, checks it against the lock's
// password, opens on a match, rewrites the password on request, and locks out.
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 256,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic                             change_req,
    input  logic [CODE_W-1:0]                lockPass,
    output logic                             readLock,
    output logic [CODE_W-1:0]                lockBuffer,
    output logic                             unlocked,
    output logic                             alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts_left,
    output lockState_e                       dbgState
);

    localparam int ATT_W     = $clog2(MAX_TRIES + 1);
    localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);
    localparam logic [TIMER_W-1:0] UNLOCK_LAST  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);

    lockState_e         state;
    lockState_e         stateNext;
    logic [ATT_W-1:0]   failCount;
    logic [ATT_W-1:0]   failNext;
    logic [TIMER_W-1:0] timer;
    logic [CODE_W-1:0]  code;
    logic [COUNT_W-1:0] count;
    logic               shift;
    logic               clr;

    assign dbgState = state;

    // One register serves both the unlock entry and the new-code entry;
    // it is wiped whenever either of those entries begins afresh.
    assign shift = digit_valid && (state == IDLE || state == ENTRY || state == NEW_ENTRY);
    assign clr   = (stateNext != state) && (stateNext == IDLE || stateNext == NEW_ENTRY);

    lock_digit_shreg u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .shift (shift),
        .digit (digit),
        .code  (code),
        .count (count)
    );

    always_comb begin
        stateNext = state;
        failNext  = failCount;
        case (state)
            IDLE: begin
                if (digit_valid) stateNext = ENTRY;
            end
            ENTRY: begin
                if (enter) stateNext = CHECK;
            end
            CHECK: begin
                if (code == lockPass) begin
                    stateNext = OPEN;
                    failNext  = '0;
                end else begin
                    failNext  = failCount + 1'b1;
                    stateNext = (failNext == ATT_W'(MAX_TRIES)) ? LOCKOUT : IDLE;
                end
            end
            OPEN: begin
                if (change_req)                stateNext = NEW_ENTRY;
                else if (timer == UNLOCK_LAST) stateNext = IDLE;
            end
            NEW_ENTRY: begin
                // A digit keyed together with enter counts toward the new code.
                if (enter) stateNext = (count != '0 || digit_valid) ? COMMIT_A : IDLE;
            end
            COMMIT_A: stateNext = COMMIT_B;
            COMMIT_B: stateNext = IDLE;
            LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    stateNext = IDLE;
                    failNext  = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Write handshake to LOCK: readLock=1 means hold; readLock=0 means LOCK may
    // take lockBuffer. readLock falls one cycle before lockBuffer changes and
    // rises one cycle after, so the change is always seen with readLock low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            failCount     <= '0;
            timer         <= '0;
            readLock      <= 1'b1;
            lockBuffer    <= '0;
            unlocked      <= 1'b0;
            alarm         <= 1'b0;
            attempts_left <= ATT_W'(MAX_TRIES);
        end else begin
            state     <= stateNext;
            failCount <= failNext;
            if (stateNext != state)                  timer <= '0;
            else if (state == OPEN || state == LOCKOUT) timer <= timer + 1'b1;
            readLock      <= !(stateNext == COMMIT_A || stateNext == COMMIT_B);
            if (state == COMMIT_A) lockBuffer <= code;
            unlocked      <= (stateNext == OPEN);
            alarm         <= (stateNext == LOCKOUT);
            attempts_left <= ATT_W'(MAX_TRIES) - failNext;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Randomized scenario bench for lock_controller with a simple LOCK model that
// latches the written code when readLock is released outside reset.
module tb_lock_controller;
  import lock_pkg::*;

  typedef logic [3:0] nib_t;

  localparam int MAX_TRIES = 3;
  localparam int UNLOCK_CYCLES = 256;
  localparam int LOCKOUT_CYCLES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'h0;
  logic        enter = 1'b0;
  logic        change_req = 1'b0;
  logic [31:0] lockPass = 32'h0;
  logic        readLock;
  logic [31:0] lockBuffer;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  attempts_left;
  lockState_e  dbgState;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          modelFails = 0;
  logic [31:0] expBuf = 32'h0;

  lock_controller #(
    .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_valid(digit_valid),
    .digit(digit),
    .enter(enter),
    .change_req(change_req),
    .lockPass(lockPass),
    .readLock(readLock),
    .lockBuffer(lockBuffer),
    .unlocked(unlocked),
    .alarm(alarm),
    .attempts_left(attempts_left),
    .dbgState(dbgState)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected code = the last (up to) 8 digits, most recent in the low nibble.
  function automatic logic [31:0] modelCode(input nib_t ds[$]);
    logic [31:0] c;
    int n;
    c = 32'h0;
    n = ds.size();
    for (int k = 0; k < 8 && k < n; k++) c = c + (32'(ds[n-1-k]) << (4 * k));
    return c;
  endfunction

  function automatic void digitsOf(input logic [31:0] p, output nib_t ds[$]);
    ds = {};
    for (int i = 7; i >= 0; i--) ds.push_back(p[4*i +: 4]);
  endfunction

  // One clock step; also plays the LOCK side of the write handshake.
  task automatic tick();
    logic        preLow;
    logic [31:0] preBuf;
    logic        preRst;
    preLow = !readLock;
    preBuf = lockBuffer;
    preRst = rst_n;
    @(posedge clk);
    #1;
    if (preLow && readLock && preRst) lockPass = preBuf;
  endtask

  task automatic runEntry(input nib_t ds[$], input bit sameCycle, output bit opened);
    logic [31:0] expCode;
    bit          expMatch;
    bit          expLock;
    bit          sawUnlock;
    int          n;
    int          cnt;
    n = ds.size();
    expCode = modelCode(ds);
    for (int i = 0; i < n; i++) begin
      digit_valid = 1'b1;
      digit = ds[i];
      enter = sameCycle && (i == n - 1);
      tick();
    end
    digit_valid = 1'b0;
    if (!sameCycle) begin
      enter = 1'b1;
      tick();
    end
    enter = 1'b0;
    nCompared++;
    if (dbgState !== CHECK) begin nMismatched++; $display("FAIL entry_to_check: got %s want CHECK", dbgState.name()); end
    nCompared++;
    if (unlocked !== 1'b0) begin nMismatched++; $display("FAIL unlocked_during_check: got %0b want 0", unlocked); end
    expMatch = (expCode == lockPass);
    if (expMatch) modelFails = 0;
    else modelFails++;
    expLock = (modelFails == MAX_TRIES);
    tick();
    nCompared++;
    if (unlocked !== expMatch) begin nMismatched++; $display("FAIL check_result: code %h pass %h unlocked got %0b want %0b", expCode, lockPass, unlocked, expMatch); end
    nCompared++;
    if (alarm !== expLock) begin nMismatched++; $display("FAIL alarm_start: got %0b want %0b", alarm, expLock); end
    nCompared++;
    if (attempts_left !== 2'(expLock ? 0 : MAX_TRIES - modelFails)) begin
      nMismatched++; $display("FAIL attempts_after_check: got %0d want %0d", attempts_left, expLock ? 0 : MAX_TRIES - modelFails);
    end
    if (expLock) begin
      cnt = 0;
      sawUnlock = 1'b0;
      while (alarm && cnt < LOCKOUT_CYCLES + 100) begin
        digit_valid = 1'($urandom_range(0, 1));
        digit = 4'($urandom_range(0, 15));
        enter = 1'($urandom_range(0, 1));
        change_req = 1'($urandom_range(0, 1));
        tick();
        if (unlocked) sawUnlock = 1'b1;
        cnt++;
      end
      digit_valid = 1'b0;
      enter = 1'b0;
      change_req = 1'b0;
      modelFails = 0;
      nCompared++;
      if (cnt !== LOCKOUT_CYCLES) begin nMismatched++; $display("FAIL alarm_length: got %0d want %0d", cnt, LOCKOUT_CYCLES); end
      nCompared++;
      if (sawUnlock) begin nMismatched++; $display("FAIL lockout_ignores_input: got unlocked 1 want 0"); end
      nCompared++;
      if (attempts_left !== 2'(MAX_TRIES)) begin nMismatched++; $display("FAIL attempts_after_lockout: got %0d want %0d", attempts_left, MAX_TRIES); end
      nCompared++;
      if (dbgState !== IDLE) begin nMismatched++; $display("FAIL lockout_exit: got %s want IDLE", dbgState.name()); end
    end
    opened = expMatch;
  endtask

  // Leave OPEN via an empty new-code entry: no write may happen.
  task automatic leaveOpen();
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    nCompared++;
    if (unlocked !== 1'b0 || dbgState !== NEW_ENTRY) begin
      nMismatched++; $display("FAIL change_req: unlocked %0b state %s want 0 NEW_ENTRY", unlocked, dbgState.name());
    end
    enter = 1'b1;
    tick();
    enter = 1'b0;
    nCompared++;
    if (dbgState !== IDLE || readLock !== 1'b1 || lockBuffer !== expBuf) begin
      nMismatched++; $display("FAIL empty_new_entry: state %s readLock %0b buf %h want IDLE 1 %h", dbgState.name(), readLock, lockBuffer, expBuf);
    end
  endtask

  // From OPEN, key a new code and follow the write handshake edge by edge.
  task automatic commitCode(input nib_t ds[$], input bit abortInB);
    logic [31:0] newCode;
    newCode = modelCode(ds);
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    for (int i = 0; i < ds.size(); i++) begin
      digit_valid = 1'b1;
      digit = ds[i];
      tick();
    end
    digit_valid = 1'b0;
    nCompared++;
    if (readLock !== 1'b1 || unlocked !== 1'b0) begin nMismatched++; $display("FAIL new_entry_hold: readLock %0b unlocked %0b want 1 0", readLock, unlocked); end
    enter = 1'b1;
    tick();
    enter = 1'b0;
    nCompared++;
    if (readLock !== 1'b0 || lockBuffer !== expBuf) begin
      nMismatched++; $display("FAIL commit_a: readLock %0b buf %h want 0 %h", readLock, lockBuffer, expBuf);
    end
    tick();
    nCompared++;
    if (readLock !== 1'b0 || lockBuffer !== newCode || dbgState !== COMMIT_B) begin
      nMismatched++; $display("FAIL commit_b: readLock %0b buf %h state %s want 0 %h COMMIT_B", readLock, lockBuffer, dbgState.name(), newCode);
    end
    if (abortInB) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      expBuf = 32'h0;
      modelFails = 0;
      nCompared++;
      if (readLock !== 1'b1 || lockBuffer !== 32'h0 || dbgState !== IDLE || attempts_left !== 2'(MAX_TRIES)) begin
        nMismatched++; $display("FAIL commit_abort: readLock %0b buf %h state %s att %0d want 1 0 IDLE %0d", readLock, lockBuffer, dbgState.name(), attempts_left, MAX_TRIES);
      end
    end else begin
      tick();
      expBuf = newCode;
      nCompared++;
      if (readLock !== 1'b1 || lockBuffer !== newCode || dbgState !== IDLE) begin
        nMismatched++; $display("FAIL commit_end: readLock %0b buf %h state %s want 1 %h IDLE", readLock, lockBuffer, dbgState.name(), newCode);
      end
      nCompared++;
      if (lockPass !== newCode) begin nMismatched++; $display("FAIL lock_written: got %h want %h", lockPass, newCode); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nCompared++;
    if (readLock !== 1'b1) begin nMismatched++; $display("FAIL reset_readLock: got %0b want 1", readLock); end
    nCompared++;
    if (lockBuffer !== 32'h0) begin nMismatched++; $display("FAIL reset_lockBuffer: got %h want 0", lockBuffer); end
    nCompared++;
    if (unlocked !== 1'b0 || alarm !== 1'b0) begin nMismatched++; $display("FAIL reset_flags: unlocked %0b alarm %0b want 0 0", unlocked, alarm); end
    nCompared++;
    if (attempts_left !== 2'(MAX_TRIES)) begin nMismatched++; $display("FAIL reset_attempts: got %0d want %0d", attempts_left, MAX_TRIES); end
    nCompared++;
    if (dbgState !== IDLE) begin nMismatched++; $display("FAIL reset_state: got %s want IDLE", dbgState.name()); end
    // An enter with nothing keyed must be ignored.
    enter = 1'b1;
    tick();
    enter = 1'b0;
    nCompared++;
    if (dbgState !== IDLE) begin nMismatched++; $display("FAIL idle_empty_enter: got %s want IDLE", dbgState.name()); end
  endtask

  task automatic test_zero_code();
    nib_t ds[$];
    bit   op;
    int   cnt;
    lockPass = 32'h0;
    ds = {};
    for (int i = 0; i < 8; i++) ds.push_back(4'h0);
    runEntry(ds, 1'b0, op);
    cnt = 0;
    while (unlocked && cnt < UNLOCK_CYCLES + 50) begin
      tick();
      cnt++;
    end
    nCompared++;
    if (cnt !== UNLOCK_CYCLES) begin nMismatched++; $display("FAIL unlock_length: got %0d want %0d", cnt, UNLOCK_CYCLES); end
    nCompared++;
    if (dbgState !== IDLE || attempts_left !== 2'(MAX_TRIES)) begin
      nMismatched++; $display("FAIL open_timeout: state %s att %0d want IDLE %0d", dbgState.name(), attempts_left, MAX_TRIES);
    end
  endtask

  task automatic test_known_code();
    nib_t ds[$];
    bit   op;
    lockPass = 32'h1234_5678;
    ds = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    runEntry(ds, 1'b0, op);
    if (op) leaveOpen();
    ds = '{4'h1, 4'h2, 4'h3};
    runEntry(ds, 1'b0, op);
    lockPass = 32'h0000_0123;
    runEntry(ds, 1'b0, op);
    if (op) leaveOpen();
  endtask

  task automatic test_lockout();
    nib_t ds[$];
    bit   op;
    lockPass = $urandom;
    for (int t = 0; t < MAX_TRIES; t++) begin
      do begin
        ds = {};
        for (int i = 0; i < 8; i++) ds.push_back(nib_t'($urandom_range(0, 15)));
      end while (modelCode(ds) == lockPass);
      runEntry(ds, 1'b0, op);
    end
    digitsOf(lockPass, ds);
    runEntry(ds, 1'b0, op);
    if (op) leaveOpen();
  endtask

  task automatic test_overflow();
    nib_t ds[$];
    bit   op;
    lockPass = 32'h3456_789A;
    ds = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    runEntry(ds, 1'b0, op);
    if (op) leaveOpen();
    lockPass = $urandom;
    digitsOf(lockPass, ds);
    for (int i = 0; i < 3; i++) ds.push_front(nib_t'($urandom_range(0, 15)));
    runEntry(ds, 1'b1, op);
    if (op) leaveOpen();
  endtask

  task automatic test_commit();
    nib_t ds[$];
    nib_t oldDs[$];
    nib_t newDs[$];
    bit   op;
    lockPass = 32'h1234_5678;
    digitsOf(lockPass, oldDs);
    runEntry(oldDs, 1'b0, op);
    newDs = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    if (op) commitCode(newDs, 1'b0);
    runEntry(oldDs, 1'b0, op);
    if (op) leaveOpen();
    runEntry(newDs, 1'b0, op);
    ds = {};
    for (int i = 0; i < int'($urandom_range(1, 8)); i++) ds.push_back(nib_t'($urandom_range(0, 15)));
    if (op) commitCode(ds, 1'b0);
    digitsOf(lockPass, newDs);
    runEntry(newDs, 1'b0, op);
    if (op) leaveOpen();
  endtask

  task automatic test_random();
    nib_t ds[$];
    bit   op;
    bit   same;
    int   n;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(1, 12);
      ds = {};
      for (int i = 0; i < n; i++) ds.push_back(nib_t'($urandom_range(0, 15)));
      same = (n > 1) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) lockPass = modelCode(ds);
      else lockPass = $urandom;
      runEntry(ds, same, op);
      if (op) leaveOpen();
    end
  endtask

  task automatic test_reset_commit();
    nib_t ds[$];
    nib_t oldDs[$];
    logic [31:0] oldPass;
    bit   op;
    oldPass = lockPass;
    digitsOf(oldPass, oldDs);
    runEntry(oldDs, 1'b0, op);
    ds = {};
    for (int i = 0; i < 8; i++) ds.push_back(nib_t'($urandom_range(0, 15)));
    if (modelCode(ds) == oldPass) ds[0] = ds[0] + 4'h1;
    if (op) commitCode(ds, 1'b1);
    nCompared++;
    if (lockPass !== oldPass) begin nMismatched++; $display("FAIL abort_keeps_pass: got %h want %h", lockPass, oldPass); end
    runEntry(oldDs, 1'b0, op);
    if (op) leaveOpen();
    runEntry(ds, 1'b0, op);
  endtask

  initial begin
    test_reset();
    test_zero_code();
    test_known_code();
    test_lockout();
    test_overflow();
    test_commit();
    test_random();
    test_reset_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
